quad_read_link_memory: RTL and testbench
========================================

Name: quad_read_link_memory

Overview:
- Data memory for a 4x4 TIA processing-element block: four independent read channels and one write channel, all speaking the link valid/ack protocol.
- The interconnect-link combine/split is a pure wire regrouping, so it sits outside this block.
- Internally holds four identical bank copies, one per read channel. Every write goes to all four banks, so read ports never conflict.
- Also provides a host MMIO port for preload and debug, plus a quiescent flag for halt detection.

Parameters:
- DEPTH, 4096, words per bank; power of two.
- DATA_WIDTH, 32, link and memory word width.
- TAG_WIDTH, 2, link tag width.
- MMIO_INDEX_WIDTH, 32, host index width.
- MMIO_DATA_WIDTH, 32, host data width; equals DATA_WIDTH.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  link-side operation enable.
- host_read_req, host_read_index  in  1 / MMIO_INDEX_WIDTH  host read request.
- host_read_ack, host_read_data  out  1 / MMIO_DATA_WIDTH  host read response.
- host_write_req, host_write_index, host_write_data  in  1 / MMIO_INDEX_WIDTH / MMIO_DATA_WIDTH  host write request.
- host_write_ack  out  1  host write done.
- rd_idx_req[k], rd_idx_data[k], rd_idx_tag[k]  in  1 / DATA_WIDTH / TAG_WIDTH  read-index link k, k=0..3.
- rd_idx_ack[k]  out  1  index consumed.
- rd_dat_req[k], rd_dat_data[k], rd_dat_tag[k]  out  1 / DATA_WIDTH / TAG_WIDTH  read-data link k.
- rd_dat_ack[k]  in  1  receiver accepts.
- wr_idx_req, wr_idx_data, wr_idx_tag  in  1 / DATA_WIDTH / TAG_WIDTH  write-index link.
- wr_dat_req, wr_dat_data, wr_dat_tag  in  1 / DATA_WIDTH / TAG_WIDTH  write-data link.
- wr_idx_ack, wr_dat_ack  out  1 each  write consumed.
- quiescent  out  1  no activity pending.

Behaviour:
- Link protocol: a transfer occurs on a rising edge where req and ack are both 1. A sender holds data and tag stable while req=1 and ack=0.
- Addressing: word address is the low log2(DEPTH) bits of the index value (wrap-around). Upper bits are ignored.
- Reset (reset=0, async):
  - rd_dat_req[k]=0, host_read_ack=0, host_write_ack=0, all output data and tags 0.
  - Memory contents are not reset.
- Read channel k:
  - One-entry output register.
  - rd_idx_ack[k] = enable & (~rd_dat_req[k] | rd_dat_ack[k]) & ~(k==0 & host read slot active).
  - On index transfer at edge N: rd_dat_data[k] = bank_k[addr] and rd_dat_tag[k] = rd_idx_tag[k], with rd_dat_req[k]=1 after edge N (1-cycle latency).
  - Back-to-back transfers sustain 1 word/cycle.
  - rd_dat_req[k] clears on a data transfer not accompanied by a new index transfer.
- Write channel:
  - wr_idx_ack = wr_dat_ack = enable & wr_idx_req & wr_dat_req & ~host_write_req.
  - Both links are consumed together on the same edge. Neither is acked alone.
  - On that edge all four banks are written at the index address with wr_dat_data; the tag is ignored.
- Same-edge read and write to the same address: the read returns the old data (read-before-write).
- enable=0:
  - All link acks are 0 and no link transfers occur.
  - Output registers hold.
  - Host accesses are still serviced.
- Host write:
  - When host_write_req=1 and host_write_ack=0, write all four banks at the edge.
  - host_write_ack=1 for exactly the following cycle, then 0 for at least one cycle before the next write.
  - Host write has priority over the link write, which stalls that cycle.
- Host read:
  - When host_read_req=1 and host_read_ack=0, read bank 0.
  - This steals bank 0's read port that cycle: rd_idx_ack[0] is forced to 0.
  - host_read_data is valid and host_read_ack=1 for exactly one cycle after the edge; data then holds until the next host read.
- quiescent = ~|rd_dat_req & ~|rd_idx_req & ~wr_idx_req & ~wr_dat_req (combinational).

Test Plan:
- Reset with all links idle -> rd_dat_req=0000, all acks 0, quiescent=1.
- Host write index 5 data 0xDEADBEEF, then a read of index 5 on each port k=0..3 with tag=2 -> each rd_dat_data[k]=0xDEADBEEF and tag=2, one cycle after its index transfer.
- rd_dat_ack[1] held 0 with a second index pending -> rd_idx_ack[1]=0 and rd_dat holds. Raise the ack -> next word follows the cycle after.
- wr_idx=0x1003 with DEPTH=4096, wr_dat=7, wr_dat_req delayed 3 cycles -> no ack until both valid. Then a read of index 3 on all ports returns 7 (wrap-around).
- Same-edge link write of 9 and port-2 read at address 10, whose old value is 4 -> read returns 4; the next read returns 9.
- Host read with rd_idx_req[0] asserted -> rd_idx_ack[0]=0 that cycle, host_read_ack pulses once with bank-0 data, port 0 proceeds the next cycle. Also enable=0 -> all link acks 0.

Source files
------------

// File: rtl/quad_read_link_memory.sv
// Four-read / one-write link memory: one bank copy per read port, every write hits all banks.
// Latency: read data registered one cycle after index transfer; host read/write ack one cycle after edge.
// Backpressure: read index acked only when output register is empty or draining; writes stall on host write.
module quad_read_link_memory #(
    parameter int DEPTH            = 4096,
    parameter int DATA_WIDTH       = 32,
    parameter int TAG_WIDTH        = 2,
    parameter int MMIO_INDEX_WIDTH = 32,
    parameter int MMIO_DATA_WIDTH  = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              host_read_req,
    input  logic [MMIO_INDEX_WIDTH-1:0]       host_read_index,
    output logic                              host_read_ack,
    output logic [MMIO_DATA_WIDTH-1:0]        host_read_data,
    input  logic                              host_write_req,
    input  logic [MMIO_INDEX_WIDTH-1:0]       host_write_index,
    input  logic [MMIO_DATA_WIDTH-1:0]        host_write_data,
    output logic                              host_write_ack,
    input  logic [3:0]                        rd_idx_req,
    input  logic [3:0][DATA_WIDTH-1:0]        rd_idx_data,
    input  logic [3:0][TAG_WIDTH-1:0]         rd_idx_tag,
    output logic [3:0]                        rd_idx_ack,
    output logic [3:0]                        rd_dat_req,
    output logic [3:0][DATA_WIDTH-1:0]        rd_dat_data,
    output logic [3:0][TAG_WIDTH-1:0]         rd_dat_tag,
    input  logic [3:0]                        rd_dat_ack,
    input  logic                              wr_idx_req,
    input  logic [DATA_WIDTH-1:0]             wr_idx_data,
    input  logic [TAG_WIDTH-1:0]              wr_idx_tag,
    input  logic                              wr_dat_req,
    input  logic [DATA_WIDTH-1:0]             wr_dat_data,
    input  logic [TAG_WIDTH-1:0]              wr_dat_tag,
    output logic                              wr_idx_ack,
    output logic                              wr_dat_ack,
    output logic                              quiescent
);

    localparam int AW = $clog2(DEPTH);

    // One full copy per read port so the four read ports never contend.
    logic [DATA_WIDTH-1:0] bank [4][DEPTH];

    logic                  host_rd_slot;
    logic                  host_wr_slot;
    logic                  link_wr_fire;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            rd_fire;
    logic [3:0]            dat_fire;
    logic                  unused_bits;

    // Host accesses are single-shot: a new slot opens only while the previous ack is low.
    assign host_rd_slot = host_read_req & ~host_read_ack;
    assign host_wr_slot = host_write_req & ~host_write_ack;

    // Index and data write links are consumed as a pair; any host write request stalls them.
    assign link_wr_fire = enable & wr_idx_req & wr_dat_req & ~host_write_req;
    assign wr_idx_ack   = link_wr_fire;
    assign wr_dat_ack   = link_wr_fire;

    assign mem_we    = host_wr_slot | link_wr_fire;
    assign mem_addr  = host_wr_slot ? host_write_index[AW-1:0] : wr_idx_data[AW-1:0];
    assign mem_wdata = host_wr_slot ? host_write_data : wr_dat_data;

    // Read index acceptance: output slot free or draining; port 0 yields to a host read.
    always_comb begin
        rd_idx_ack = '0;
        for (int k = 0; k < 4; k++) begin
            rd_idx_ack[k] = enable & (~rd_dat_req[k] | rd_dat_ack[k]) & ~((k == 0) & host_rd_slot);
        end
    end

    assign rd_fire  = rd_idx_req & rd_idx_ack;
    assign dat_fire = rd_dat_req & rd_dat_ack & {4{enable}};

    assign quiescent = ~|rd_dat_req & ~|rd_idx_req & ~wr_idx_req & ~wr_dat_req;

    // Address upper bits and write tags carry no meaning inside the memory.
    assign unused_bits = ^{host_read_index, host_write_index, rd_idx_data, wr_idx_data,
                           wr_idx_tag, wr_dat_tag};

    // Broadcast every write to all bank copies; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                bank[b][mem_addr] <= mem_wdata;
            end
        end
    end

    // Per-port output register: load on index transfer, release on a bare data transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_dat_req  <= '0;
            rd_dat_data <= '0;
            rd_dat_tag  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (rd_fire[k]) begin
                    rd_dat_data[k] <= bank[k][rd_idx_data[k][AW-1:0]];
                    rd_dat_tag[k]  <= rd_idx_tag[k];
                    rd_dat_req[k]  <= 1'b1;
                end else if (dat_fire[k]) begin
                    rd_dat_req[k]  <= 1'b0;
                end
            end
        end
    end

    // Host port: one-cycle acks, read data held until the next host read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            host_read_ack  <= 1'b0;
            host_read_data <= '0;
            host_write_ack <= 1'b0;
        end else begin
            host_read_ack  <= host_rd_slot;
            host_write_ack <= host_wr_slot;
            if (host_rd_slot) begin
                host_read_data <= bank[0][host_read_index[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_quad_read_link_memory.sv
module tb_quad_read_link_memory;

    typedef struct packed {
        logic [1:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic              clock;
    logic              reset;
    logic              enable;
    logic              host_read_req;
    logic [31:0]       host_read_index;
    logic              host_read_ack;
    logic [31:0]       host_read_data;
    logic              host_write_req;
    logic [31:0]       host_write_index;
    logic [31:0]       host_write_data;
    logic              host_write_ack;
    logic [3:0]        rd_idx_req;
    logic [3:0][31:0]  rd_idx_data;
    logic [3:0][1:0]   rd_idx_tag;
    logic [3:0]        rd_idx_ack;
    logic [3:0]        rd_dat_req;
    logic [3:0][31:0]  rd_dat_data;
    logic [3:0][1:0]   rd_dat_tag;
    logic [3:0]        rd_dat_ack;
    logic              wr_idx_req;
    logic [31:0]       wr_idx_data;
    logic [1:0]        wr_idx_tag;
    logic              wr_dat_req;
    logic [31:0]       wr_dat_data;
    logic [1:0]        wr_dat_tag;
    logic              wr_idx_ack;
    logic              wr_dat_ack;
    logic              quiescent;

    int          n_cmp  = 0;
    int          n_fail = 0;
    exp_t        rd_q [4][$];
    logic [31:0] host_q [$];
    logic [31:0] model_mem [int];
    exp_t        popped;
    logic [31:0] host_popped;

    quad_read_link_memory dut (
        .clock(clock), .reset(reset), .enable(enable),
        .host_read_req(host_read_req), .host_read_index(host_read_index),
        .host_read_ack(host_read_ack), .host_read_data(host_read_data),
        .host_write_req(host_write_req), .host_write_index(host_write_index),
        .host_write_data(host_write_data), .host_write_ack(host_write_ack),
        .rd_idx_req(rd_idx_req), .rd_idx_data(rd_idx_data), .rd_idx_tag(rd_idx_tag),
        .rd_idx_ack(rd_idx_ack),
        .rd_dat_req(rd_dat_req), .rd_dat_data(rd_dat_data), .rd_dat_tag(rd_dat_tag),
        .rd_dat_ack(rd_dat_ack),
        .wr_idx_req(wr_idx_req), .wr_idx_data(wr_idx_data), .wr_idx_tag(wr_idx_tag),
        .wr_dat_req(wr_dat_req), .wr_dat_data(wr_dat_data), .wr_dat_tag(wr_dat_tag),
        .wr_idx_ack(wr_idx_ack), .wr_dat_ack(wr_dat_ack),
        .quiescent(quiescent)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic host_wr(input logic [31:0] idx, input logic [31:0] data);
        host_write_req   = 1'b1;
        host_write_index = idx;
        host_write_data  = data;
        tick();
        host_write_req   = 1'b0;
        settle();
        check("host_wr_ack_pulse", host_write_ack, 1'b1);
        tick();
        check("host_wr_ack_drop", host_write_ack, 1'b0);
    endtask

    // Scoreboard: at the falling edge decide which transfers the next rising edge performs.
    always @(negedge clock) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                if (rd_dat_req[k] && rd_dat_ack[k] && enable) begin
                    n_cmp++;
                    assert (rd_q[k].size() > 0) else begin
                        n_fail++;
                        $error("FAIL sb_underflow port=%0d observed_size=%0d expected_size>0", k, rd_q[k].size());
                    end
                    if (rd_q[k].size() > 0) begin
                        popped = rd_q[k].pop_front();
                        check($sformatf("sb_rd_port%0d", k), {rd_dat_tag[k], rd_dat_data[k]}, popped);
                    end
                end
            end
            if (host_read_ack) begin
                n_cmp++;
                assert (host_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_host_underflow observed_size=%0d expected_size>0", host_q.size());
                end
                if (host_q.size() > 0) begin
                    host_popped = host_q.pop_front();
                    check("sb_host_rd", host_read_data, host_popped);
                end
            end
            // Reads sample the memory model before this edge's write lands.
            for (int k = 0; k < 4; k++) begin
                if (rd_idx_req[k] && rd_idx_ack[k]) begin
                    rd_q[k].push_back({rd_idx_tag[k], model_mem[int'(rd_idx_data[k][11:0])]});
                end
            end
            if (host_read_req && !host_read_ack) begin
                host_q.push_back(model_mem[int'(host_read_index[11:0])]);
            end
            if (host_write_req && !host_write_ack) begin
                model_mem[int'(host_write_index[11:0])] = host_write_data;
            end else if (enable && wr_idx_req && wr_dat_req) begin
                model_mem[int'(wr_idx_data[11:0])] = wr_dat_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0;
        host_read_req = 1'b0; host_read_index = '0;
        host_write_req = 1'b0; host_write_index = '0; host_write_data = '0;
        rd_idx_req = '0; rd_idx_data = '0; rd_idx_tag = '0; rd_dat_ack = '0;
        wr_idx_req = 1'b0; wr_idx_data = '0; wr_idx_tag = '0;
        wr_dat_req = 1'b0; wr_dat_data = '0; wr_dat_tag = '0;
        #3;
        // Reset state
        check("rst_dat_req", rd_dat_req, 4'b0000);
        check("rst_host_rd_ack", host_read_ack, 1'b0);
        check("rst_host_wr_ack", host_write_ack, 1'b0);
        check("rst_host_rd_data", host_read_data, 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_dat_data%0d", k), {rd_dat_tag[k], rd_dat_data[k]}, 34'h0);
        end
        check("rst_idx_ack", rd_idx_ack, 4'b0000);
        check("rst_wr_ack", {wr_idx_ack, wr_dat_ack}, 2'b00);
        check("rst_quiescent", quiescent, 1'b1);
        repeat (2) tick();
        reset  = 1'b1;
        enable = 1'b1;
        settle();
        check("idle_idx_ack", rd_idx_ack, 4'b1111);
        check("idle_wr_ack", {wr_idx_ack, wr_dat_ack}, 2'b00);

        // Host write, then read index 5 on all ports with tag 2
        host_wr(32'd5, 32'hDEADBEEF);
        rd_idx_req = 4'hF;
        rd_dat_ack = 4'hF;
        for (int k = 0; k < 4; k++) begin
            rd_idx_data[k] = 32'd5;
            rd_idx_tag[k]  = 2'd2;
        end
        settle();
        check("rd5_idx_ack", rd_idx_ack, 4'hF);
        check("rd5_busy", quiescent, 1'b0);
        tick();
        rd_idx_req = 4'h0;
        settle();
        check("rd5_dat_req", rd_dat_req, 4'hF);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rd5_data%0d", k), rd_dat_data[k], 32'hDEADBEEF);
            check($sformatf("rd5_tag%0d", k), rd_dat_tag[k], 2'd2);
        end
        tick();
        check("rd5_drained", rd_dat_req, 4'h0);

        // Backpressure on port 1
        host_wr(32'd20, 32'h11);
        host_wr(32'd21, 32'h22);
        rd_dat_ack = 4'b1101;
        rd_idx_req = 4'b0010;
        rd_idx_data[1] = 32'd20; rd_idx_tag[1] = 2'd1;
        settle();
        check("bp_first_ack", rd_idx_ack[1], 1'b1);
        tick();
        rd_idx_data[1] = 32'd21; rd_idx_tag[1] = 2'd3;
        settle();
        check("bp_idx_ack_low", rd_idx_ack[1], 1'b0);
        check("bp_req", rd_dat_req[1], 1'b1);
        check("bp_data", {rd_dat_tag[1], rd_dat_data[1]}, {2'd1, 32'h11});
        tick();
        check("bp_hold_ack", rd_idx_ack[1], 1'b0);
        check("bp_hold_data", {rd_dat_tag[1], rd_dat_data[1]}, {2'd1, 32'h11});
        rd_dat_ack = 4'hF;
        settle();
        check("bp_release_ack", rd_idx_ack[1], 1'b1);
        tick();
        rd_idx_req = 4'h0;
        settle();
        check("bp_next_req", rd_dat_req[1], 1'b1);
        check("bp_next_data", {rd_dat_tag[1], rd_dat_data[1]}, {2'd3, 32'h22});
        tick();
        check("bp_drained", rd_dat_req[1], 1'b0);

        // Link write with delayed data link, wrap-around address
        wr_idx_req = 1'b1; wr_idx_data = 32'h1003; wr_idx_tag = 2'd1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("wr_wait_ack", {wr_idx_ack, wr_dat_ack}, 2'b00);
            tick();
        end
        wr_dat_req = 1'b1; wr_dat_data = 32'd7; wr_dat_tag = 2'd2;
        settle();
        check("wr_pair_ack", {wr_idx_ack, wr_dat_ack}, 2'b11);
        tick();
        wr_idx_req = 1'b0; wr_dat_req = 1'b0;
        settle();
        check("wr_ack_drop", {wr_idx_ack, wr_dat_ack}, 2'b00);
        rd_idx_req = 4'hF;
        for (int k = 0; k < 4; k++) begin
            rd_idx_data[k] = 32'd3;
            rd_idx_tag[k]  = 2'd1;
        end
        tick();
        rd_idx_req = 4'h0;
        settle();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wrap_data%0d", k), rd_dat_data[k], 32'd7);
        end
        tick();

        // Same-edge write and read at address 10
        host_wr(32'd10, 32'd4);
        wr_idx_req = 1'b1; wr_idx_data = 32'd10;
        wr_dat_req = 1'b1; wr_dat_data = 32'd9;
        rd_idx_req = 4'b0100; rd_idx_data[2] = 32'd10; rd_idx_tag[2] = 2'd1;
        settle();
        check("rbw_wr_ack", wr_idx_ack, 1'b1);
        check("rbw_rd_ack", rd_idx_ack[2], 1'b1);
        tick();
        wr_idx_req = 1'b0; wr_dat_req = 1'b0;
        rd_idx_tag[2] = 2'd2;
        settle();
        check("rbw_old", {rd_dat_tag[2], rd_dat_data[2]}, {2'd1, 32'd4});
        tick();
        rd_idx_req = 4'h0;
        settle();
        check("rbw_new", {rd_dat_tag[2], rd_dat_data[2]}, {2'd2, 32'd9});
        tick();

        // Host write priority over link write
        host_write_req = 1'b1; host_write_index = 32'd30; host_write_data = 32'hAA;
        wr_idx_req = 1'b1; wr_idx_data = 32'd31;
        wr_dat_req = 1'b1; wr_dat_data = 32'hBB;
        settle();
        check("prio_stall", {wr_idx_ack, wr_dat_ack}, 2'b00);
        tick();
        host_write_req = 1'b0;
        settle();
        check("prio_host_ack", host_write_ack, 1'b1);
        check("prio_link_go", {wr_idx_ack, wr_dat_ack}, 2'b11);
        tick();
        wr_idx_req = 1'b0; wr_dat_req = 1'b0;
        check("prio_host_ack_drop", host_write_ack, 1'b0);
        rd_idx_req = 4'b1100;
        rd_idx_data[3] = 32'd30; rd_idx_tag[3] = 2'd0;
        rd_idx_data[2] = 32'd31; rd_idx_tag[2] = 2'd0;
        tick();
        rd_idx_req = 4'h0;
        settle();
        check("prio_rd30", rd_dat_data[3], 32'hAA);
        check("prio_rd31", rd_dat_data[2], 32'hBB);
        tick();

        // Host read steals port 0 for one cycle
        host_read_req = 1'b1; host_read_index = 32'd5;
        rd_idx_req = 4'b0011;
        rd_idx_data[0] = 32'd3; rd_idx_tag[0] = 2'd3;
        rd_idx_data[1] = 32'd5; rd_idx_tag[1] = 2'd0;
        settle();
        check("hrd_steal_ack", rd_idx_ack, 4'b1110);
        tick();
        host_read_req = 1'b0;
        rd_idx_req = 4'b0001;
        settle();
        check("hrd_ack", host_read_ack, 1'b1);
        check("hrd_data", host_read_data, 32'hDEADBEEF);
        check("hrd_port0_idle", rd_dat_req[0], 1'b0);
        check("hrd_port0_ack", rd_idx_ack[0], 1'b1);
        tick();
        rd_idx_req = 4'h0;
        settle();
        check("hrd_port0_data", {rd_dat_req[0], rd_dat_tag[0], rd_dat_data[0]}, {1'b1, 2'd3, 32'd7});
        check("hrd_ack_drop", host_read_ack, 1'b0);
        check("hrd_data_hold", host_read_data, 32'hDEADBEEF);
        tick();

        // enable=0: links frozen, host still serviced
        rd_dat_ack = 4'b0111;
        rd_idx_req = 4'b1000; rd_idx_data[3] = 32'd5; rd_idx_tag[3] = 2'd2;
        tick();
        enable = 1'b0;
        rd_idx_req = 4'hF;
        for (int k = 0; k < 4; k++) rd_idx_data[k] = 32'd5;
        rd_dat_ack = 4'hF;
        wr_idx_req = 1'b1; wr_idx_data = 32'd50;
        wr_dat_req = 1'b1; wr_dat_data = 32'h66;
        host_write_req = 1'b1; host_write_index = 32'd40; host_write_data = 32'h55;
        settle();
        check("dis_idx_ack", rd_idx_ack, 4'h0);
        check("dis_wr_ack", {wr_idx_ack, wr_dat_ack}, 2'b00);
        check("dis_busy", quiescent, 1'b0);
        check("dis_req", rd_dat_req, 4'b1000);
        tick();
        host_write_req = 1'b0;
        settle();
        check("dis_host_wr_ack", host_write_ack, 1'b1);
        check("dis_hold", {rd_dat_req, rd_dat_tag[3], rd_dat_data[3]}, {4'b1000, 2'd2, 32'hDEADBEEF});
        tick();
        rd_idx_req = 4'h0; wr_idx_req = 1'b0; wr_dat_req = 1'b0;
        enable = 1'b1;
        settle();
        check("en_pending", quiescent, 1'b0);
        tick();
        check("en_drained", rd_dat_req, 4'h0);
        check("en_quiescent", quiescent, 1'b1);
        host_read_req = 1'b1; host_read_index = 32'd40;
        tick();
        host_read_req = 1'b0;
        settle();
        check("dis_host_wr_data", host_read_data, 32'h55);
        tick();

        for (int k = 0; k < 4; k++) begin
            check($sformatf("sb_left_port%0d", k), rd_q[k].size(), 0);
        end
        check("sb_left_host", host_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
